// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns framed command bytes from a UART receiver into
// register write/read strobes and queues a short response for the UART
// transmitter. Frame: SYNC, CMD, ADDR_H, ADDR_L, DATA_H, DATA_L[, CHK].
// Optional feature: define UART_CMD_CHECKSUM_EN to append an XOR checksum
// byte (CMD ^ ADDR_H ^ ADDR_L ^ DATA_H ^ DATA_L) to every frame.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        frame_err,
  output logic        busy
);

`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_PING  = 8'h03;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  localparam logic [7:0] RSP_PONG  = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_EXEC,
    S_RD_WAIT,
    S_RESP
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]    resp_hi_reg, resp_hi_next;
  logic [7:0]    resp_lo_reg, resp_lo_next;
  logic          resp_two_reg, resp_two_next;
  logic          resp_sel_reg, resp_sel_next;
  logic          tx_send_reg, tx_send_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          frame_err_reg, frame_err_next;

  // Slot 1 is CMD; slot 0 (SYNC) is never stored.
  logic [7:0]    frame_reg [1:LAST_IDX];
  logic [7:0]    cmd;
  logic          chk_ok;
  logic          exec_ok;

  assign cmd = frame_reg[1];

`ifdef UART_CMD_CHECKSUM_EN
  assign chk_ok = ((frame_reg[1] ^ frame_reg[2] ^ frame_reg[3] ^
                    frame_reg[4] ^ frame_reg[5]) == frame_reg[6]);
`else
  assign chk_ok = 1'b1;
`endif

  // Strobes are decoded from the EXEC state so each lasts exactly one cycle;
  // addresses and data come straight from the captured frame bytes.
  assign exec_ok   = (state_reg == S_EXEC) && chk_ok;
  assign wr_en     = exec_ok && (cmd == CMD_WRITE);
  assign rd_en     = exec_ok && (cmd == CMD_READ);
  assign wr_addr   = {frame_reg[2], frame_reg[3]};
  assign wr_data   = {frame_reg[4], frame_reg[5]};
  assign rd_addr   = {frame_reg[2], frame_reg[3]};
  assign busy      = (state_reg != S_IDLE);
  assign tx_send   = tx_send_reg;
  assign tx_data   = tx_data_reg;
  assign frame_err = frame_err_reg;

  // Store each received frame byte in the slot selected by the byte index
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_reg <= '{default: 8'h00};
    end else if (state_reg == S_RECV && rx_valid) begin
      frame_reg[idx_reg] <= rx_data;
    end
  end

  // State and control register update
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg     <= S_IDLE;
      idx_reg       <= 3'd0;
      tmo_reg       <= '0;
      resp_hi_reg   <= 8'h00;
      resp_lo_reg   <= 8'h00;
      resp_two_reg  <= 1'b0;
      resp_sel_reg  <= 1'b0;
      tx_send_reg   <= 1'b0;
      tx_data_reg   <= 8'h00;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      tmo_reg       <= tmo_next;
      resp_hi_reg   <= resp_hi_next;
      resp_lo_reg   <= resp_lo_next;
      resp_two_reg  <= resp_two_next;
      resp_sel_reg  <= resp_sel_next;
      tx_send_reg   <= tx_send_next;
      tx_data_reg   <= tx_data_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic: frame reception, command decode and response sequencing
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    tmo_next       = tmo_reg;
    resp_hi_next   = resp_hi_reg;
    resp_lo_next   = resp_lo_reg;
    resp_two_next  = resp_two_reg;
    resp_sel_next  = resp_sel_reg;
    tx_send_next   = 1'b0;
    tx_data_next   = tx_data_reg;
    frame_err_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        idx_next = 3'd0;
        tmo_next = '0;
        // Anything but the sync byte is line noise and is dropped silently.
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_next = S_RECV;
          idx_next   = 3'd1;
        end
      end

      S_RECV: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          tmo_next = '0;
          if (idx_reg == LAST_IDX) begin
            state_next = S_EXEC;
            idx_next   = 3'd0;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else if (tmo_reg == TMO_LAST) begin
          frame_err_next = 1'b1;
          state_next     = S_IDLE;
          idx_next       = 3'd0;
          tmo_next       = '0;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end

      S_EXEC: begin
        state_next    = S_RESP;
        resp_two_next = 1'b0;
        resp_sel_next = 1'b0;
        if (!chk_ok) begin
          frame_err_next = 1'b1;
          resp_hi_next   = RSP_NAK;
        end else begin
          case (cmd)
            CMD_WRITE: resp_hi_next = RSP_ACK;
            CMD_READ:  state_next   = S_RD_WAIT;
            CMD_PING:  resp_hi_next = RSP_PONG;
            default: begin
              frame_err_next = 1'b1;
              resp_hi_next   = RSP_NAK;
            end
          endcase
        end
      end

      S_RD_WAIT: begin
        // Read data is valid in the cycle after the rd_en strobe.
        resp_hi_next  = rd_data[15:8];
        resp_lo_next  = rd_data[7:0];
        resp_two_next = 1'b1;
        resp_sel_next = 1'b0;
        state_next    = S_RESP;
      end

      S_RESP: begin
        // The transmitter may not have raised tx_busy yet in the cycle
        // right after a send, so that cycle never issues another send.
        if (!tx_busy && !tx_send_reg) begin
          tx_send_next = 1'b1;
          tx_data_next = resp_sel_reg ? resp_lo_reg : resp_hi_reg;
          if (resp_two_reg && !resp_sel_reg) begin
            resp_sel_next = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Bytes arriving while a command is being handled are dropped.
    if (rx_valid && (state_reg == S_EXEC || state_reg == S_RD_WAIT ||
                     state_reg == S_RESP)) begin
      frame_err_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: scoreboard queues hold the expected
// write/read strobes and response bytes; a negedge monitor pops and compares
// them as the DUT produces output. Works with or without UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 40;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        frame_err;
  logic        busy;

  int check_cnt = 0;
  int err_cnt   = 0;
  int fe_cnt    = 0;

  logic [7:0]  exp_tx [$];
  logic [31:0] exp_wr [$];
  logic [15:0] exp_rd [$];

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard plus behavioural models of the read port and UART tx
  initial begin : monitor
    int          busy_left;
    logic        prev_rd;
    logic [31:0] w;
    logic [15:0] ra;
    logic [7:0]  tb;
    busy_left = 0;
    prev_rd   = 1'b0;
    tx_busy   = 1'b0;
    rd_data   = 16'hDEAD;
    forever begin
      @(negedge sys_clk);
      if (wr_en || rd_en || tx_send)
        check_val("strobe_onehot", 32'(wr_en) + 32'(rd_en) + 32'(tx_send), 32'd1);
      if (wr_en) begin
        $display("wr  addr=%04h data=%04h", wr_addr, wr_data);
        if (exp_wr.size() == 0) check_val("wr_unexpected", 32'd1, 32'd0);
        else begin
          w = exp_wr.pop_front();
          check_val("wr_addr", 32'(wr_addr), 32'(w[31:16]));
          check_val("wr_data", 32'(wr_data), 32'(w[15:0]));
        end
      end
      if (rd_en) begin
        $display("rd  addr=%04h", rd_addr);
        if (exp_rd.size() == 0) check_val("rd_unexpected", 32'd1, 32'd0);
        else begin
          ra = exp_rd.pop_front();
          check_val("rd_addr", 32'(rd_addr), 32'(ra));
        end
      end
      if (tx_send) begin
        $display("tx  byte=%02h", tx_data);
        check_val("tx_while_busy", 32'(busy_left != 0), 32'd0);
        if (exp_tx.size() == 0) check_val("tx_unexpected", 32'd1, 32'd0);
        else begin
          tb = exp_tx.pop_front();
          check_val("tx_data", 32'(tx_data), 32'(tb));
        end
        busy_left = 5;
      end
      if (frame_err) begin
        fe_cnt++;
        $display("frame_err pulse");
      end
      // Read port: data valid only in the cycle following rd_en.
      rd_data = prev_rd ? 16'hCAFE : 16'hDEAD;
      prev_rd = rd_en;
      // Transmitter raises busy one cycle after tx_send, for four cycles.
      tx_busy = (busy_left != 0) && (busy_left != 5);
      if (busy_left > 0) busy_left--;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] ah, input logic [7:0] al,
                            input logic [7:0] dh, input logic [7:0] dl);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(ah);
    send_byte(al);
    send_byte(dh);
    send_byte(dl);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd ^ ah ^ al ^ dh ^ dl);
`endif
  endtask

  // Every byte lands exactly on the cycle where the timeout would expire.
  task automatic send_frame_slow(input logic [7:0] cmd, input logic [7:0] ah, input logic [7:0] al,
                                 input logic [7:0] dh, input logic [7:0] dl);
    logic [7:0] bytes [7];
    int         n;
    bytes[0] = 8'hA5; bytes[1] = cmd; bytes[2] = ah; bytes[3] = al;
    bytes[4] = dh;    bytes[5] = dl;  bytes[6] = cmd ^ ah ^ al ^ dh ^ dl;
`ifdef UART_CMD_CHECKSUM_EN
    n = 7;
`else
    n = 6;
`endif
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i]);
      if (i != n - 1) repeat (TMO - 2) @(negedge sys_clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check_val({tag, "_done"}, 32'(n < 400), 32'd1);
    repeat (8) @(negedge sys_clk);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic expect_fe(input string tag, input int n);
    check_val({tag, "_frame_err"}, 32'(fe_cnt), 32'(n));
    fe_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tx_send"},   32'(tx_send),   32'd0);
    check_val({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check_val({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check_val({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check_val({tag, "_wr_data"},   32'(wr_data),   32'd0);
    check_val({tag, "_rd_en"},     32'(rd_en),     32'd0);
    check_val({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    check_val({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check_val({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    sys_rst  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    fe_cnt = 0;

    // Write
    exp_wr.push_back(32'h1234BEEF);
    exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h12, 8'h34, 8'hBE, 8'hEF);
    wait_done("write");
    expect_fe("write", 0);

    // Read
    exp_rd.push_back(16'h0010);
    exp_tx.push_back(8'hCA);
    exp_tx.push_back(8'hFE);
    send_frame(8'h02, 8'h00, 8'h10, 8'h00, 8'h00);
    wait_done("read");
    expect_fe("read", 0);

    // Checksum byte 0x00
`ifdef UART_CMD_CHECKSUM_EN
    exp_tx.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h00);
    wait_done("badchk");
    expect_fe("badchk", 1);
`else
    exp_wr.push_back(32'h1234BEEF);
    exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h12, 8'h34, 8'hBE, 8'hEF);
    wait_done("badchk_frame");
    send_byte(8'h00);
    wait_done("badchk_noise");
    expect_fe("badchk", 0);
`endif

    // Unknown command
    exp_tx.push_back(8'h15);
    send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done("badcmd");
    expect_fe("badcmd", 1);

    // Inter-byte timeout, then a ping
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    wait_done("timeout");
    expect_fe("timeout", 1);
    exp_tx.push_back(8'h55);
    send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done("ping_after_tmo");
    expect_fe("ping_after_tmo", 0);

    // Bytes arriving exactly on the expiry cycle are accepted
    exp_tx.push_back(8'h55);
    send_frame_slow(8'h03, 8'h11, 8'h22, 8'h33, 8'h44);
    wait_done("slow_ping");
    expect_fe("slow_ping", 0);

    // Reset mid-frame aborts it
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("midrst");
    sys_rst = 1'b0;
    repeat (TMO + 10) @(negedge sys_clk);
    expect_fe("midrst", 0);
    exp_wr.push_back(32'hABCD0001);
    exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'hAB, 8'hCD, 8'h00, 8'h01);
    wait_done("write_after_rst");
    expect_fe("write_after_rst", 0);

    // Noise in IDLE, then a ping
    send_byte(8'h00);
    send_byte(8'h7E);
    exp_tx.push_back(8'h55);
    send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done("noise_ping");
    expect_fe("noise_ping", 0);

    // Byte arriving while the response is pending is dropped with frame_err
    exp_tx.push_back(8'h55);
    send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    send_byte(8'h11);
    wait_done("busy_byte");
    expect_fe("busy_byte", 1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
